// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_arb_pkg                                               |
// | Description : Shared types and constants for the FIFO write-port arbiter.|
// |               Provides the arbiter state encoding, the default requester |
// |               count and burst length, and a reference round-robin picker |
// |               (rr_first) usable by any block needing the same ordering.  |
// | Macros      : WIDTH (default data width, 8 when not supplied)            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`ifndef WIDTH
`define WIDTH 8
`endif

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int C_DEF_NUM_REQ   = 4;
  localparam int C_DEF_BURST_LEN = 1;
  localparam int C_MAX_REQ       = 8;

  // One-hot of the first set bit of req when scanning ptr, ptr+1, ...
  // modulo num_req. Bits at or above num_req are ignored.
  function automatic logic [C_MAX_REQ-1:0] rr_first(
    input logic [C_MAX_REQ-1:0] req,
    input int unsigned          ptr,
    input int unsigned          num_req
  );
    logic [C_MAX_REQ-1:0] oh;
    logic                 found;
    int unsigned          idx;
    oh    = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < C_MAX_REQ; k++) begin
      idx = (ptr + k) % num_req;
      if (!found && (k < num_req) && req[idx[2:0]]) begin
        oh[idx[2:0]] = 1'b1;
        found        = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_wr_arbiter_if                                         |
// | Description : Bundle between NUM_REQ producers, the arbiter and the FIFO |
// |               write port.                                                |
// |   req       producers -> arbiter   per-requester valid                   |
// |   req_data  producers -> arbiter   beat of requester i at [i*WIDTH+:W]   |
// |   gnt       arbiter -> producers   one-hot accept                        |
// |   full      FIFO -> arbiter        FIFO full                             |
// |   overflow  FIFO -> arbiter        FIFO overflow (design error)          |
// |   wr_en     arbiter -> FIFO        write enable                          |
// |   wdata     arbiter -> FIFO        write data                            |
// |   ovf_err   arbiter -> system      sticky overflow flag                  |
// |   beat_cnt  arbiter -> system      per-requester accepted-beat counters  |
// | Modports    : master = producer/FIFO environment, slave = arbiter        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`ifndef WIDTH
`define WIDTH 8
`endif

interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = C_DEF_NUM_REQ,
  parameter int WIDTH   = `WIDTH,
  parameter int CNT_W   = 16
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     full;
  logic                     overflow;
  logic                     wr_en;
  logic [WIDTH-1:0]         wdata;
  logic                     ovf_err;
  logic [NUM_REQ*CNT_W-1:0] beat_cnt;

  // Environment side: producers plus the FIFO status lines.
  modport master (
    output req, req_data, full, overflow,
    input  gnt, wr_en, wdata, ovf_err, beat_cnt
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, full, overflow,
    output gnt, wr_en, wdata, ovf_err, beat_cnt
  );

endinterface
`default_nettype wire

// File: rtl/fifo_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_rr_pick                                               |
// | Description : Combinational round-robin picker. Rotates req so that bit  |
// |               i_ptr lands at position 0, isolates the lowest set bit,    |
// |               and rotates the result back.                               |
// |   i_req   in   NUM_REQ   request vector                                  |
// |   i_ptr   in   PTR_W     highest-priority index                          |
// |   o_pick  out  NUM_REQ   one-hot winner (zero when no request)           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = C_DEF_NUM_REQ,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  wire logic [NUM_REQ-1:0] i_req,
  input  wire logic [PTR_W-1:0]   i_ptr,
  output logic      [NUM_REQ-1:0] o_pick
);

  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_rot_pick;

  function automatic logic [PTR_W-1:0] f_wrap(input int a);
    return PTR_W'(a % NUM_REQ);
  endfunction

  // Rotate right by i_ptr: w_rot[j] is requester (j + ptr) mod NUM_REQ.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_rot[j] = i_req[f_wrap(j + int'(i_ptr))];
    end
  end

  // Two's-complement trick keeps only the lowest set bit.
  assign w_rot_pick = w_rot & (~w_rot + NUM_REQ'(1));

  // Rotate back into requester numbering.
  always_comb begin
    o_pick = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      o_pick[f_wrap(j + int'(i_ptr))] = w_rot_pick[j];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_wr_arbiter                                            |
// | Description : Round-robin arbiter sharing one FIFO write port among      |
// |               NUM_REQ producers, with optional burst lock (BURST_LEN>1)  |
// |               keeping an owner's beats contiguous. Zero-latency data     |
// |               pass-through; grants are combinational and never issued    |
// |               while the FIFO is full or reset is asserted.               |
// |   wr_clk   in   1     write-side clock                                   |
// |   res      in   1     synchronous active-high reset                      |
// |   bus      slave     req/req_data/full/overflow in,                      |
// |                      gnt/wr_en/wdata/ovf_err/beat_cnt out                |
// | Macros      : FIFO_ARB_STATS_EN - build saturating per-requester beat    |
// |               counters; when undefined beat_cnt is tied to zero.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`ifndef WIDTH
`define WIDTH 8
`endif

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = C_DEF_NUM_REQ,
  parameter int WIDTH     = `WIDTH,
  parameter int BURST_LEN = C_DEF_BURST_LEN,
  parameter int CNT_W     = 16
) (
  input wire logic   wr_clk,
  input wire logic   res,
  fifo_wr_arbiter_if.slave bus
);

  localparam int C_PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int C_BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [C_PTR_W-1:0]  C_LAST_REQ     = C_PTR_W'(NUM_REQ - 1);
  localparam logic [C_BEAT_W-1:0] C_BURST_PENULT = C_BEAT_W'(BURST_LEN - 1);

  arb_state_e          r_state_q, w_state_d;
  logic [C_PTR_W-1:0]  r_ptr_q, w_ptr_d;
  logic [C_PTR_W-1:0]  r_owner_q, w_owner_d;
  logic [C_BEAT_W-1:0] r_beats_q, w_beats_d;
  logic                r_ovf_err_q, w_ovf_err_d;

  logic [NUM_REQ-1:0]  w_pick;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [C_PTR_W-1:0]  w_win_idx;
  logic [WIDTH-1:0]    w_wdata;
  logic                w_owner_req;
  logic                w_wr_en;

  function automatic logic [C_PTR_W-1:0] f_next(input logic [C_PTR_W-1:0] idx);
    return (idx == C_LAST_REQ) ? '0 : idx + C_PTR_W'(1);
  endfunction

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (C_PTR_W)
  ) u_rr_pick (
    .i_req  (bus.req),
    .i_ptr  (r_ptr_q),
    .o_pick (w_pick)
  );

  assign w_owner_req = bus.req[r_owner_q];

  // Grant: nothing while full or in reset; during a burst only the owner.
  always_comb begin
    w_gnt = '0;
    if (!res && !bus.full) begin
      if (r_state_q == IDLE) begin
        w_gnt = w_pick;
      end else if (w_owner_req) begin
        w_gnt[r_owner_q] = 1'b1;
      end
    end
  end

  assign w_wr_en = |(bus.req & w_gnt);

  // Winner index and data mux from the one-hot grant.
  always_comb begin
    w_win_idx = '0;
    w_wdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_idx = C_PTR_W'(i);
        w_wdata   = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_d   = r_state_q;
    w_ptr_d     = r_ptr_q;
    w_owner_d   = r_owner_q;
    w_beats_d   = r_beats_q;
    w_ovf_err_d = r_ovf_err_q | bus.overflow;
    case (r_state_q)
      IDLE: begin
        if (w_wr_en) begin
          w_beats_d = C_BEAT_W'(1);
          if (BURST_LEN > 1) begin
            w_state_d = LOCK;
            w_owner_d = w_win_idx;
          end else begin
            w_ptr_d = f_next(w_win_idx);
          end
        end
      end
      LOCK: begin
        // A full FIFO freezes the burst in place; otherwise either the
        // owner supplies a beat or its dropped request ends the burst.
        if (!bus.full) begin
          if (w_owner_req) begin
            w_beats_d = r_beats_q + C_BEAT_W'(1);
            if (r_beats_q == C_BURST_PENULT) begin
              w_state_d = IDLE;
              w_ptr_d   = f_next(r_owner_q);
            end
          end else begin
            w_state_d = IDLE;
            w_ptr_d   = f_next(r_owner_q);
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (res) begin
      r_state_q   <= IDLE;
      r_ptr_q     <= '0;
      r_owner_q   <= '0;
      r_beats_q   <= '0;
      r_ovf_err_q <= 1'b0;
    end else begin
      r_state_q   <= w_state_d;
      r_ptr_q     <= w_ptr_d;
      r_owner_q   <= w_owner_d;
      r_beats_q   <= w_beats_d;
      r_ovf_err_q <= w_ovf_err_d;
    end
  end

  assign bus.gnt     = w_gnt;
  assign bus.wr_en   = w_wr_en;
  assign bus.wdata   = w_wdata;
  assign bus.ovf_err = r_ovf_err_q;

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt_q [NUM_REQ];
  logic [CNT_W-1:0] w_cnt_d [NUM_REQ];

  // Saturating accepted-beat counters.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cnt_d[i] = r_cnt_q[i];
      if (bus.req[i] && w_gnt[i] && !(&r_cnt_q[i])) begin
        w_cnt_d[i] = r_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (res) begin
        r_cnt_q[i] <= '0;
      end else begin
        r_cnt_q[i] <= w_cnt_d[i];
      end
    end
  end

  always_comb begin
    bus.beat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.beat_cnt[i*CNT_W +: CNT_W] = r_cnt_q[i];
    end
  end
`else
  assign bus.beat_cnt = {(NUM_REQ*CNT_W){1'b0}};
`endif

endmodule
`default_nettype wire
